// File: rtl/pixel_stream_packer.sv
// Packs non-blanking 8-bit pixels four at a time into 32-bit words, queues them
// in a fall-through FIFO and writes them to frame memory over a valid/ready port.
module pixel_stream_packer #(
  parameter int unsigned           width      = 420,
  parameter int unsigned           height     = 240,
  parameter int unsigned           FIFO_DEPTH = 16,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            din,
  input  logic                  blanking_in,
  input  logic                  validin,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int unsigned FRAME_PIX = width * height;
  localparam int unsigned PIX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIX - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  logic [1:0]            r_lane;
  logic [23:0]           r_pack;
  logic [PIX_W-1:0]      r_pix_cnt;
  logic [ADDR_WIDTH-1:0] r_next_addr;

  logic [31:0]           r_mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
  logic                  r_mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_frame_done;
  logic                  r_overflow;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_push_ok;
  logic [31:0]           w_word;

  always_comb begin
    w_accept  = validin & ~blanking_in;
    w_last    = (r_pix_cnt == LAST_PIX);
    w_push    = w_accept && (r_lane == 2'd3);
    w_pop     = (r_count != '0) && wr_ready;
    // A full FIFO still takes the new word when the head leaves on the same edge.
    w_push_ok = w_push && ((r_count < DEPTH_C) || w_pop);
    w_word    = {din, r_pack};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lane      <= '0;
      r_pack      <= '0;
      r_pix_cnt   <= '0;
      r_next_addr <= BASE_ADDR;
    end else if (w_accept) begin
      r_lane <= r_lane + 2'd1;
      case (r_lane)
        2'd0:    r_pack[7:0]   <= din;
        2'd1:    r_pack[15:8]  <= din;
        2'd2:    r_pack[23:16] <= din;
        default: ;
      endcase
      r_pix_cnt <= w_last ? '0 : r_pix_cnt + PIX_W'(1);
      // The address advances for dropped words too, keeping frame alignment.
      if (w_push)
        r_next_addr <= w_last ? BASE_ADDR : r_next_addr + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_addr[i] <= BASE_ADDR;
        r_mem_last[i] <= 1'b0;
      end
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem_data[r_wptr] <= w_word;
        r_mem_addr[r_wptr] <= r_next_addr;
        r_mem_last[r_wptr] <= w_last;
        r_wptr             <= r_wptr + PTR_W'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
      r_frame_done <= w_pop && r_mem_last[r_rptr];
      if (w_push && !w_push_ok)
        r_overflow <= 1'b1;
    end
  end

  always_comb begin
    wr_valid   = (r_count != '0);
    wr_addr    = r_mem_addr[r_rptr];
    wr_data    = r_mem_data[r_rptr];
    frame_done = r_frame_done;
    overflow   = r_overflow;
  end

endmodule
